// File: rtl/uart_pkg.sv
// Shared definitions for the UART parity engines: parity mode encodings,
// the engine state enum, and the parity-bit function used by both shifters.
package uart_pkg;

    localparam logic [2:0] PAR_EVEN  = 3'd0;
    localparam logic [2:0] PAR_ODD   = 3'd1;
    localparam logic [2:0] PAR_MARK  = 3'd2;
    localparam logic [2:0] PAR_SPACE = 3'd3;
    localparam logic [2:0] PAR_NONE  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY
    } par_state_t;

    // Codes 5..7 are reserved and behave exactly like NONE.
    function automatic logic par_is_none(input logic [2:0] mode);
        return mode >= PAR_NONE;
    endfunction

    // Parity bit for a frame whose data bits XOR to acc.
    function automatic logic par_bit(input logic [2:0] mode, input logic acc);
        logic bit_val;
        case (mode)
            PAR_EVEN:  bit_val = acc;
            PAR_ODD:   bit_val = ~acc;
            PAR_MARK:  bit_val = 1'b1;
            PAR_SPACE: bit_val = 1'b0;
            default:   bit_val = 1'b0;
        endcase
        return bit_val;
    endfunction

endpackage

// File: rtl/uart_parity_engine.sv
// Serial parity generator/checker. Accumulates parity as data bits stream
// past, offers the parity bit for TX, checks the received parity bit for RX
// and keeps a saturating parity-error count.
module uart_parity_engine
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           mode,
    input  logic                 frame_start,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 par_rdy,
    output logic                 par_out,
    output logic                 chk_valid,
    output logic                 par_err,
    output logic                 frame_done,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    par_state_t               state, state_next;
    logic [2:0]               mode_q, mode_next;
    logic                     acc, acc_next;
    logic [CNT_W-1:0]         cnt, cnt_next;
    logic                     busy_next;
    logic                     par_rdy_next;
    logic                     par_out_next;
    logic                     chk_valid_next;
    logic                     par_err_next;
    logic                     frame_done_next;
    logic [ERR_CNT_W-1:0]     err_cnt_next;

    // Next-state and next-output logic for the frame FSM and error counter.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next      = state;
        mode_next       = mode_q;
        acc_next        = acc;
        cnt_next        = cnt;
        par_rdy_next    = par_rdy;
        par_out_next    = par_out;
        chk_valid_next  = 1'b0;
        par_err_next    = 1'b0;
        frame_done_next = 1'b0;

        if (frame_start) begin
            // Starts a frame from any state; an in-flight frame is abandoned
            // silently and a coincident bit_valid is dropped.
            state_next   = ST_DATA;
            mode_next    = mode;
            acc_next     = 1'b0;
            cnt_next     = '0;
            par_rdy_next = 1'b0;
            par_out_next = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Stray bits between frames are ignored.
                end
                ST_DATA: begin
                    if (bit_valid) begin
                        acc_next = acc ^ bit_in;
                        cnt_next = cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            cnt_next = '0;
                            if (par_is_none(mode_q)) begin
                                frame_done_next = 1'b1;
                                state_next      = ST_IDLE;
                            end else begin
                                par_out_next = par_bit(mode_q, acc ^ bit_in);
                                par_rdy_next = 1'b1;
                                state_next   = ST_PARITY;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_valid) begin
                        chk_valid_next  = 1'b1;
                        frame_done_next = 1'b1;
                        par_err_next    = (bit_in != par_out);
                        par_rdy_next    = 1'b0;
                        par_out_next    = 1'b0;
                        state_next      = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        busy_next = (state_next != ST_IDLE);

        // The counter follows the registered par_err pulse; a clear that
        // lands on an error leaves that one error counted.
        err_cnt_next = err_cnt;
        if (err_clr) begin
            err_cnt_next = par_err ? ERR_CNT_W'(1) : '0;
        end else if (par_err && (err_cnt != '1)) begin
            err_cnt_next = err_cnt + ERR_CNT_W'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its input as it was before this clock edge.
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= PAR_EVEN;
            acc        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            par_rdy    <= 1'b0;
            par_out    <= 1'b0;
            chk_valid  <= 1'b0;
            par_err    <= 1'b0;
            frame_done <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_next;
            mode_q     <= mode_next;
            acc        <= acc_next;
            cnt        <= cnt_next;
            busy       <= busy_next;
            par_rdy    <= par_rdy_next;
            par_out    <= par_out_next;
            chk_valid  <= chk_valid_next;
            par_err    <= par_err_next;
            frame_done <= frame_done_next;
            err_cnt    <= err_cnt_next;
        end
    end

endmodule

// File: tb/tb_uart_parity_engine.sv
// Bench for uart_parity_engine: four instances (DATA_W 8/8/5/9, one with a
// 2-bit error counter) share one stimulus stream; a frame-level reference
// model tracks each of them every cycle, and directed tables cover the
// documented frames, aborts, NONE mode and counter saturation.
module tb_uart_parity_engine;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode = 3'd0;
    logic       frame_start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       err_clr = 1'b0;

    logic [N-1:0] busy_o, rdy_o, pout_o, chk_o, perr_o, done_o;
    logic [7:0]   ec8, ec5, ec9;
    logic [1:0]   ec_sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_parity_engine #(.DATA_W(8), .ERR_CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .mode(mode), .frame_start(frame_start),
        .bit_valid(bit_valid), .bit_in(bit_in), .err_clr(err_clr),
        .busy(busy_o[0]), .par_rdy(rdy_o[0]), .par_out(pout_o[0]),
        .chk_valid(chk_o[0]), .par_err(perr_o[0]), .frame_done(done_o[0]),
        .err_cnt(ec8));

    uart_parity_engine #(.DATA_W(8), .ERR_CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .mode(mode), .frame_start(frame_start),
        .bit_valid(bit_valid), .bit_in(bit_in), .err_clr(err_clr),
        .busy(busy_o[1]), .par_rdy(rdy_o[1]), .par_out(pout_o[1]),
        .chk_valid(chk_o[1]), .par_err(perr_o[1]), .frame_done(done_o[1]),
        .err_cnt(ec_sat));

    uart_parity_engine #(.DATA_W(5), .ERR_CNT_W(8)) u_dut5 (
        .clk(clk), .rst(rst), .mode(mode), .frame_start(frame_start),
        .bit_valid(bit_valid), .bit_in(bit_in), .err_clr(err_clr),
        .busy(busy_o[2]), .par_rdy(rdy_o[2]), .par_out(pout_o[2]),
        .chk_valid(chk_o[2]), .par_err(perr_o[2]), .frame_done(done_o[2]),
        .err_cnt(ec5));

    uart_parity_engine #(.DATA_W(9), .ERR_CNT_W(8)) u_dut9 (
        .clk(clk), .rst(rst), .mode(mode), .frame_start(frame_start),
        .bit_valid(bit_valid), .bit_in(bit_in), .err_clr(err_clr),
        .busy(busy_o[3]), .par_rdy(rdy_o[3]), .par_out(pout_o[3]),
        .chk_valid(chk_o[3]), .par_err(perr_o[3]), .frame_done(done_o[3]),
        .err_cnt(ec9));

    // ---------------- reference model (frame level) ----------------
    typedef struct {
        bit        in_data;   // collecting data bits
        bit        in_par;    // waiting for the parity bit
        int        nbits;
        bit [15:0] bits;
        bit [2:0]  md;
        bit        rdy, pout, chk, perr, done;
        int        errs;
    } mdl_t;

    mdl_t mdl [N];
    int   dws  [N] = '{8, 8, 5, 9};
    int   emax [N] = '{255, 3, 255, 255};

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.in_data = 0; z.in_par = 0; z.nbits = 0; z.bits = '0; z.md = '0;
        z.rdy = 0; z.pout = 0; z.chk = 0; z.perr = 0; z.done = 0; z.errs = 0;
        return z;
    endfunction

    // Parity bit from the population count of the frame's data bits.
    function automatic bit ref_parity(input bit [2:0] md, input bit [15:0] bits, input int dw);
        int ones = 0;
        for (int i = 0; i < dw; i++) ones += int'(bits[i]);
        case (md)
            3'd0:    return bit'(ones % 2);
            3'd1:    return bit'(1 - ones % 2);
            3'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int dw, input int em);
        mdl_t n = m;
        if (rst) return mdl_zero();
        n.chk = 0; n.perr = 0; n.done = 0;
        if (err_clr)                      n.errs = m.perr ? 1 : 0;
        else if (m.perr && m.errs < em)   n.errs = m.errs + 1;
        if (frame_start) begin
            n.in_data = 1; n.in_par = 0; n.nbits = 0; n.bits = '0;
            n.md = mode; n.rdy = 0; n.pout = 0;
        end else if (bit_valid && m.in_data) begin
            n.bits[m.nbits] = bit_in;
            n.nbits = m.nbits + 1;
            if (n.nbits == dw) begin
                n.in_data = 0;
                if (m.md >= 3'd4) n.done = 1;
                else begin
                    n.in_par = 1; n.rdy = 1;
                    n.pout = ref_parity(m.md, n.bits, dw);
                end
            end
        end else if (bit_valid && m.in_par) begin
            n.chk = 1; n.done = 1; n.perr = (bit_in != m.pout);
            n.in_par = 0; n.rdy = 0; n.pout = 0;
        end
        return n;
    endfunction

    function automatic logic [21:0] mdl_vec(input mdl_t m);
        return {m.in_data | m.in_par, m.rdy, m.pout, m.chk, m.perr, m.done, m.errs[15:0]};
    endfunction

    function automatic logic [21:0] dut_vec(input int i);
        logic [15:0] e;
        case (i)
            0:       e = {8'd0, ec8};
            1:       e = {14'd0, ec_sat};
            2:       e = {8'd0, ec5};
            default: e = {8'd0, ec9};
        endcase
        return {busy_o[i], rdy_o[i], pout_o[i], chk_o[i], perr_o[i], done_o[i], e};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the models with the inputs seen at the edge, then
    // compare every instance against its model.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < N; i++) mdl[i] = mdl_step(mdl[i], dws[i], emax[i]);
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("scoreboard dut%0d", i), 32'(dut_vec(i)), 32'(mdl_vec(mdl[i])));
    endtask

    task automatic start_frame(input logic [2:0] m);
        frame_start = 1'b1; mode = m; bit_valid = 1'b0;
        tick();
        frame_start = 1'b0;
        mode = 3'($urandom);   // later mode changes must not matter
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1; bit_in = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_data8(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    typedef struct {
        logic [2:0] mode;
        logic [7:0] data;
        logic       pbit;
        logic       exp_pout;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [7];
    bit   saw;

    initial begin
        vecs[0] = '{3'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'd0};  // EVEN, clean
        vecs[1] = '{3'd1, 8'h01, 1'b1, 1'b0, 1'b1, 8'd1};  // ODD, error
        vecs[2] = '{3'd2, 8'h3C, 1'b0, 1'b1, 1'b1, 8'd2};  // MARK, error
        vecs[3] = '{3'd3, 8'h7F, 1'b0, 1'b0, 1'b0, 8'd2};  // SPACE, clean
        vecs[4] = '{3'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'd2};  // EVEN, clean
        vecs[5] = '{3'd1, 8'h00, 1'b1, 1'b1, 1'b0, 8'd2};  // ODD, clean
        vecs[6] = '{3'd0, 8'h07, 1'b1, 1'b1, 1'b0, 8'd2};  // EVEN odd count

        for (int i = 0; i < N; i++) mdl[i] = mdl_zero();

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) check($sformatf("reset dut%0d", i), 32'(dut_vec(i)), 32'd0);
        tick();

        // Table of complete frames on the 8-bit instance
        for (int v = 0; v < 7; v++) begin
            start_frame(vecs[v].mode);
            check("busy after start", 32'(busy_o[0]), 32'd1);
            send_data8(vecs[v].data);
            check("par_rdy", 32'(rdy_o[0]), 32'd1);
            check("par_out", 32'(pout_o[0]), 32'(vecs[v].exp_pout));
            send_bit(vecs[v].pbit);
            check("chk_valid", 32'(chk_o[0]), 32'd1);
            check("par_err", 32'(perr_o[0]), 32'(vecs[v].exp_err));
            check("frame_done", 32'(done_o[0]), 32'd1);
            check("busy at done", 32'(busy_o[0]), 32'd0);
            tick();
            check("chk_valid one cycle", 32'(chk_o[0]), 32'd0);
            check("err_cnt", 32'(ec8), 32'(vecs[v].exp_cnt));
        end

        // NONE and reserved mode 6 with 3-cycle gaps
        for (int k = 0; k < 2; k++) begin
            start_frame(k == 0 ? 3'd4 : 3'd6);
            saw = 1'b0;
            for (int i = 0; i < 8; i++) begin
                send_bit(1'($urandom));
                if (i < 7) begin
                    if (rdy_o[0] | chk_o[0] | done_o[0]) saw = 1'b1;
                    repeat (3) begin
                        tick();
                        if (rdy_o[0] | chk_o[0] | done_o[0]) saw = 1'b1;
                    end
                end
            end
            check("none frame_done", 32'(done_o[0]), 32'd1);
            check("none par_rdy", 32'(rdy_o[0]), 32'd0);
            check("none chk_valid", 32'(chk_o[0]), 32'd0);
            check("none early pulse", 32'(saw), 32'd0);
            tick();
            check("none done one cycle", 32'(done_o[0]), 32'd0);
        end

        // Abort after 4 bits; restart with a coincident (dropped) bit
        start_frame(3'd0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        frame_start = 1'b1; mode = 3'd0; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        frame_start = 1'b0; bit_valid = 1'b0;
        check("abort no done", 32'(done_o[0]), 32'd0);
        check("abort no chk", 32'(chk_o[0]), 32'd0);
        check("abort busy", 32'(busy_o[0]), 32'd1);
        send_data8(8'hFF);
        check("restart par_out", 32'(pout_o[0]), 32'd0);
        send_bit(1'b0);
        check("restart chk", 32'(chk_o[0]), 32'd1);
        check("restart err", 32'(perr_o[0]), 32'd0);

        // Saturation of the 2-bit counter
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        for (int f = 0; f < 5; f++) begin
            start_frame(3'd1);
            send_data8(8'h01);
            send_bit(1'b1);
        end
        tick();
        check("sat err_cnt", 32'(ec_sat), 32'd3);
        check("wide err_cnt", 32'(ec8), 32'd5);

        // err_clr coincident with par_err
        start_frame(3'd1);
        send_data8(8'h01);
        send_bit(1'b1);
        check("perr before clr", 32'(perr_o[0]), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("clr+err wide", 32'(ec8), 32'd1);
        check("clr+err sat", 32'(ec_sat), 32'd1);

        // Back-to-back bits with random modes, then gappy random traffic
        for (int c = 0; c < 4000; c++) begin
            frame_start = ($urandom_range(0, 19) == 0);
            mode        = 3'($urandom);
            bit_valid   = (c < 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);
            bit_in      = 1'($urandom);
            err_clr     = ($urandom_range(0, 63) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            tick();
        end
        frame_start = 1'b0; bit_valid = 1'b0; err_clr = 1'b0; rst = 1'b0;
        tick();

        // Reset in the middle of a frame
        start_frame(3'd1);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) check($sformatf("mid rst dut%0d", i), 32'(dut_vec(i)), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Parametrised serial parity generator/checker for the full-duplex UART core. Accumulates parity bit-by-bit as data bits stream through the TX or RX shifter and supports five parity modes. In RX use it checks the received parity bit and keeps a saturating error count. In TX use it supplies the parity bit once the last data bit has been shifted. One instance sits beside each direction's shift register.

## Interface
Parameters:
- DATA_W, 8, data bits per frame; legal 5..9
- ERR_CNT_W, 8, width of saturating parity-error counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mode  in  3  parity mode; sampled only on frame_start: 0 EVEN, 1 ODD, 2 MARK, 3 SPACE, 4 NONE; 5..7 treated as NONE
- frame_start  in  1  single-cycle pulse; begins a new frame
- bit_valid  in  1  bit_in carries a frame bit this cycle
- bit_in  in  1  serial data bit (LSB first) or received parity bit
- err_clr  in  1  clears err_cnt
- busy  out  1  engine inside a frame (DATA or PARITY state)
- par_rdy  out  1  all data bits accepted; par_out valid
- par_out  out  1  expected/generated parity bit
- chk_valid  out  1  one-cycle pulse; parity bit checked
- par_err  out  1  one-cycle pulse with chk_valid; mismatch
- frame_done  out  1  one-cycle pulse at end of every completed frame
- err_cnt  out  ERR_CNT_W  saturating parity-error count

## Operation
- States: IDLE, DATA, PARITY.
- IDLE: bit_valid is ignored. frame_start latches mode, clears acc and bit counter, and moves to DATA.
- DATA: each bit_valid does acc ^= bit_in and cnt++. On the bit where cnt == DATA_W-1:
  - mode NONE: pulse frame_done and go to IDLE.
  - otherwise: register par_out, set par_rdy, and go to PARITY.
- par_out values: EVEN = acc; ODD = ~acc; MARK = 1; SPACE = 0. "acc" is the XOR of all DATA_W bits.
- PARITY: the next bit_valid is the parity bit.
  - Pulse chk_valid and frame_done.
  - par_err = (bit_in != par_out).
  - Clear par_rdy and go to IDLE.
- TX use: the transmitter reads par_out while par_rdy=1, then feeds the parity bit back on bit_valid to close the frame. par_err is ignored in TX use.
- frame_start in DATA or PARITY aborts the current frame: no chk_valid, no frame_done, no counter change. Engine restarts in DATA with the newly sampled mode. A bit_valid in the same cycle as frame_start is dropped, in every state.
- err_cnt increments on each par_err and saturates at all-ones.
  - err_clr alone: err_cnt becomes 0.
  - err_clr together with par_err: err_cnt becomes 1.
- mode changes mid-frame have no effect.

## Timing
- Reset values: state IDLE; busy, par_rdy, par_out, chk_valid, par_err, frame_done = 0; err_cnt = 0; acc and cnt = 0.
- All outputs are registered.
- busy rises the cycle after frame_start.
- par_rdy and par_out are valid the cycle after the last data bit is accepted. They hold until the parity bit is accepted, a new frame starts, or rst.
- chk_valid, par_err and frame_done assert the cycle after the parity bit is accepted and last exactly one cycle. busy falls in that same cycle.
- For NONE mode, frame_done asserts the cycle after the last data bit is accepted.
- bit_valid may be asserted back-to-back every cycle, or with arbitrary gaps. No throughput loss.
- rst mid-frame returns to the reset state the next cycle, with no pulses emitted.

## Structure
- Shared package uart_pkg holds:
  - mode encodings PAR_EVEN/PAR_ODD/PAR_MARK/PAR_SPACE/PAR_NONE
  - the state enum
  - a function par_bit(mode, acc) that returns the parity bit
- The RX shifter and the TX shifter reuse the same function.
- The bit counter width is $clog2(DATA_W).
- Single flat module; no sub-module needed.

## Test plan
- DATA_W=8, EVEN, data 0xA5 (LSB first), parity bit 0: par_rdy with par_out=0; then chk_valid=1, par_err=0, frame_done=1; err_cnt stays 0.
- ODD, data 0x01, parity bit 1: par_out=0, par_err=1, err_cnt goes 0→1. MARK with parity bit 0: par_err=1. SPACE with parity bit 0: no error.
- NONE (and mode=6), 8 bits with 3-cycle gaps: frame_done 1 cycle after the 8th bit; par_rdy and chk_valid never assert.
- frame_start after 4 data bits, then a full EVEN frame 0xFF with parity bit 0: no pulses from the aborted frame; new frame checks clean. bit_valid coincident with frame_start is dropped.
- ERR_CNT_W=2: 5 error frames give err_cnt = 3 (saturated). err_clr together with par_err gives err_cnt = 1.
- DATA_W=5 and DATA_W=9 with back-to-back bit_valid and a random mode sweep, plus rst asserted mid-frame: outputs match the scoreboard; after rst, all outputs are 0 and state is IDLE.
